// File: rtl/axi_rd_resp_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and the axi_rd_resp responder.
//   master: drives arvalid/arid/araddr/arlen/arsize/arburst and rready
//   slave : drives arready and rvalid/rid/rdata/rlast/rresp
interface axi_rd_resp_if;
  logic         arvalid;
  logic         arready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [5:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic         rlast;
  logic [1:0]   rresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rlast, rresp
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rlast, rresp
  );
endinterface

// File: rtl/axi_rd_resp.sv
// AXI4 read-channel slave responder. Queues read requests in a small FIFO and
// returns bursts whose 128-bit data is derived purely from the request address.
//   clk  : AXI clock
//   rest : synchronous active-high reset
//   bus  : AR/R channels (slave side)
// Each 32-bit lane k of a beat carries (beat_addr + 4k) ^ DATA_SEED; illegal
// requests return zero data with SLVERR but keep the requested beat count.
module axi_rd_resp #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter logic [31:0] DATA_SEED  = 32'h0
) (
  input  logic         clk,
  input  logic         rest,
  axi_rd_resp_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned BEAT_W = 6;
  localparam int unsigned LANES  = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [5:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  // FIFO storage and bookkeeping
  ar_req_t            fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               arready_q, arready_d;

  // Burst context captured at pop
  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [3:0]         ctx_id_q, ctx_id_d;
  logic [31:0]        ctx_addr_q, ctx_addr_d;
  logic [5:0]         ctx_len_q, ctx_len_d;
  logic [1:0]         ctx_burst_q, ctx_burst_d;
  logic               ctx_err_q, ctx_err_d;

  // Registered R channel outputs
  logic               rvalid_q, rvalid_d;
  logic [3:0]         rid_q, rid_d;
  logic [127:0]       rdata_q, rdata_d;
  logic               rlast_q, rlast_d;
  logic [1:0]         rresp_q, rresp_d;

  logic               arready_gated;
  logic               push;
  logic               pop;
  ar_req_t            push_req;
  ar_req_t            head;
  logic               head_err;
  logic               load_beat;
  logic [31:0]        wrap_mask;
  logic [31:0]        beat_offs;
  logic [31:0]        beat_addr;
  logic [127:0]       beat_data;

  // arready must read low for the whole time reset is held, not just after the edge
  assign arready_gated = arready_q & ~rest;
  assign push          = bus.arvalid & arready_gated;
  assign pop           = (state_q == ST_IDLE) && (count_q != '0);
  assign head          = fifo_mem_q[rd_ptr_q];

  assign push_req = '{id: bus.arid, addr: bus.araddr, len: bus.arlen,
                      size: bus.arsize, burst: bus.arburst};

  // Illegal size, reserved burst type, or WRAP with a non-power-of-two length
  assign head_err = (head.size != 3'b100) || (head.burst == 2'b11) ||
                    ((head.burst == 2'b10) &&
                     !(head.len inside {6'd1, 6'd3, 6'd7, 6'd15}));

  assign bus.arready = arready_gated;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;

  // FIFO pointer/occupancy next state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    arready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // FSM next state, burst context and R output next values
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    ctx_id_d    = ctx_id_q;
    ctx_addr_d  = ctx_addr_q;
    ctx_len_d   = ctx_len_q;
    ctx_burst_d = ctx_burst_q;
    ctx_err_d   = ctx_err_q;
    rvalid_d    = rvalid_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    load_beat   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          ctx_id_d    = head.id;
          ctx_addr_d  = head.addr & 32'hFFFF_FFF0;
          ctx_len_d   = head.len;
          ctx_burst_d = head.burst;
          ctx_err_d   = head_err;
          beat_d      = '0;
          lat_d       = LAT_W'(RD_LAT);
          state_d     = (RD_LAT == 0) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = ST_BURST;
      end
      ST_BURST: begin
        // First cycle in BURST loads beat 0 into the output registers
        if (!rvalid_q) begin
          load_beat = 1'b1;
        end else if (bus.rready) begin
          if (beat_q == ctx_len_q) begin
            state_d  = ST_IDLE;
            beat_d   = '0;
            rvalid_d = 1'b0;
            rid_d    = '0;
            rdata_d  = '0;
            rlast_d  = 1'b0;
            rresp_d  = 2'b00;
          end else begin
            beat_d    = beat_q + BEAT_W'(1);
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address of the beat about to be presented; WRAP lengths are powers of two
    // when legal, so the wrap boundary is a simple mask
    wrap_mask = {22'b0, ctx_len_q, 4'hF};
    beat_offs = {22'b0, beat_d, 4'h0};
    unique case (ctx_burst_q)
      2'b01:   beat_addr = ctx_addr_q + beat_offs;
      2'b10:   beat_addr = (ctx_addr_q & ~wrap_mask) |
                           ((ctx_addr_q + beat_offs) & wrap_mask);
      default: beat_addr = ctx_addr_q;
    endcase

    beat_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      beat_data[32*k +: 32] = (beat_addr + (k << 2)) ^ DATA_SEED;
    end

    if (load_beat) begin
      rvalid_d = 1'b1;
      rid_d    = ctx_id_q;
      rlast_d  = (beat_d == ctx_len_q);
      rresp_d  = ctx_err_q ? 2'b10 : 2'b00;
      rdata_d  = ctx_err_q ? '0 : beat_data;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      arready_q   <= 1'b0;
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      ctx_id_q    <= '0;
      ctx_addr_q  <= '0;
      ctx_len_q   <= '0;
      ctx_burst_q <= '0;
      ctx_err_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rlast_q     <= 1'b0;
      rresp_q     <= 2'b00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      arready_q   <= arready_d;
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      ctx_id_q    <= ctx_id_d;
      ctx_addr_q  <= ctx_addr_d;
      ctx_len_q   <= ctx_len_d;
      ctx_burst_q <= ctx_burst_d;
      ctx_err_q   <= ctx_err_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rlast_q     <= rlast_d;
      rresp_q     <= rresp_d;
    end
  end

  // FIFO storage; push is already blocked while reset is held
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_req;
  end

endmodule

// File: tb/tb_axi_rd_resp.sv
// Directed bench for axi_rd_resp with an in-order scoreboard of expected R beats.
module tb_axi_rd_resp;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned RD_LAT     = 2;
  localparam logic [31:0] DATA_SEED  = 32'h0;

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
    logic         last;
    logic [1:0]   resp;
  } beat_t;

  logic clk = 1'b0;
  logic rest;

  axi_rd_resp_if bus();

  axi_rd_resp #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RD_LAT     (RD_LAT),
    .DATA_SEED  (DATA_SEED)
  ) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_cmp   = 0;
  int    n_bad   = 0;
  int    n_beats = 0;
  logic  last_acc = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference beat address, written with the explicit modulo formulation
  function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [5:0] len,
                                             input logic [1:0] burst, input int beat);
    logic [31:0] a, s, l;
    a = addr & 32'hFFFF_FFF0;
    s = (32'(len) + 32'd1) * 32'd16;
    case (burst)
      2'b00:   return a;
      2'b01:   return a + 32'(beat) * 32'd16;
      default: begin
        l = a & ~(s - 32'd1);
        return l + ((a - l + 32'(beat) * 32'd16) % s);
      end
    endcase
  endfunction

  task automatic push_burst(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    beat_t       b;
    logic        err;
    logic [31:0] ba;
    err = (size != 3'b100) || (burst == 2'b11) ||
          ((burst == 2'b10) && !(len == 6'd1 || len == 6'd3 || len == 6'd7 || len == 6'd15));
    for (int i = 0; i <= int'(len); i++) begin
      ba     = model_addr(addr, len, burst, i);
      b.id   = id;
      b.last = (i == int'(len));
      b.resp = err ? 2'b10 : 2'b00;
      b.data = '0;
      if (!err) begin
        for (int k = 0; k < 4; k++) b.data[32*k +: 32] = (ba + 32'(4 * k)) ^ DATA_SEED;
      end
      exp_q.push_back(b);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then advance past the rising edge
  task automatic cycle();
    logic  hs, acc;
    beat_t e;
    @(negedge clk);
    hs  = bus.rvalid && bus.rready;
    acc = bus.arvalid && bus.arready;
    if (hs) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL stale_beat: observed beat rid=%0h expected no beat", bus.rid);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("r_id",   128'(bus.rid),   128'(e.id));
        check("r_data", bus.rdata,       e.data);
        check("r_last", 128'(bus.rlast), 128'(e.last));
        check("r_resp", 128'(bus.rresp), 128'(e.resp));
      end
      n_beats++;
    end
    if (acc) push_burst(bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst);
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (last_acc) break;
    end
    check("ar_accept", 128'(last_acc), 128'(1'b1));
    bus.arvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    check("drain_left", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int b0;

    rest        = 1'b1;
    bus.arvalid = 1'b0;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.arlen   = '0;
    bus.arsize  = '0;
    bus.arburst = '0;
    bus.rready  = 1'b0;
    repeat (3) cycle();

    // Reset state
    check("rst_rvalid",  128'(bus.rvalid),  128'(0));
    check("rst_arready", 128'(bus.arready), 128'(0));
    check("rst_rdata",   bus.rdata,         128'(0));
    check("rst_rlast",   128'(bus.rlast),   128'(0));
    check("rst_rid",     128'(bus.rid),     128'(0));
    check("rst_rresp",   128'(bus.rresp),   128'(0));
    rest = 1'b0;
    cycle();
    check("post_rst_arready", 128'(bus.arready), 128'(1));

    // Single INCR burst, latency and first-beat lanes
    bus.rready = 1'b1;
    send_ar(4'd3, 32'h0000_1000, 6'd3, 3'b100, 2'b01);
    check("lat_e0_rvalid", 128'(bus.rvalid), 128'(0));
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("lat_rvalid_low", 128'(bus.rvalid), 128'(0));
    end
    cycle();
    check("lat_rvalid_high", 128'(bus.rvalid), 128'(1));
    check("incr_beat0_data", bus.rdata, 128'h0000100C_00001008_00001004_00001000);
    check("incr_beat0_rid",  128'(bus.rid), 128'(3));
    check("incr_beat0_last", 128'(bus.rlast), 128'(0));
    drain(40);

    // WRAP burst crossing the wrap boundary
    send_ar(4'd5, 32'h0000_2038, 6'd3, 3'b100, 2'b10);
    for (int i = 0; i < 20 && !bus.rvalid; i++) cycle();
    check("wrap_beat0_lane0", 128'(bus.rdata[31:0]), 128'(32'h2030));
    drain(40);

    // Backpressure in the middle of an 8-beat burst
    b0 = n_beats;
    send_ar(4'd6, 32'h0000_3000, 6'd7, 3'b100, 2'b01);
    for (int i = 0; i < 40 && exp_q.size() > 5; i++) cycle();
    bus.rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_rvalid", 128'(bus.rvalid), 128'(1));
      check("bp_rdata",  bus.rdata,        exp_q[0].data);
      check("bp_rid",    128'(bus.rid),    128'(exp_q[0].id));
      check("bp_rlast",  128'(bus.rlast),  128'(exp_q[0].last));
    end
    bus.rready = 1'b1;
    drain(40);
    check("bp_beat_total", 128'(n_beats - b0), 128'(8));

    // FIFO full: first request is popped at once, the next four fill the FIFO
    bus.rready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_ar(4'(i), 32'h0000_6000 + 32'(i) * 32'h100, 6'd1, 3'b100, 2'b01);
      if (i == 4) check("full_arready_4", 128'(bus.arready), 128'(1));
    end
    check("full_arready_5", 128'(bus.arready), 128'(0));
    repeat (2) begin
      cycle();
      check("full_arready_hold", 128'(bus.arready), 128'(0));
    end
    bus.rready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 8; i++) cycle();
    check("full_arready_pre_pop", 128'(bus.arready), 128'(0));
    cycle();
    check("full_arready_post_pop", 128'(bus.arready), 128'(1));
    drain(80);

    // Error responses and FIXED burst
    send_ar(4'd7,  32'h0000_7000, 6'd1, 3'b010, 2'b01);
    send_ar(4'd8,  32'h0000_7100, 6'd2, 3'b100, 2'b10);
    send_ar(4'd11, 32'h0000_7200, 6'd0, 3'b100, 2'b11);
    send_ar(4'd12, 32'h0000_4008, 6'd2, 3'b100, 2'b00);
    drain(80);

    // Reset during beat 2 of an 8-beat burst with two more requests queued
    b0 = n_beats;
    send_ar(4'd9, 32'h0000_5000, 6'd7, 3'b100, 2'b01);
    send_ar(4'd1, 32'h0000_5100, 6'd3, 3'b100, 2'b01);
    send_ar(4'd2, 32'h0000_5200, 6'd3, 3'b100, 2'b01);
    for (int i = 0; i < 40 && (n_beats - b0) < 2; i++) cycle();
    check("mid_rst_beat2_valid", 128'(bus.rvalid), 128'(1));
    rest       = 1'b1;
    bus.rready = 1'b0;
    #1;
    check("mid_rst_arready_now", 128'(bus.arready), 128'(0));
    exp_q.delete();
    repeat (2) begin
      cycle();
      check("mid_rst_rvalid",  128'(bus.rvalid),  128'(0));
      check("mid_rst_arready", 128'(bus.arready), 128'(0));
      check("mid_rst_rlast",   128'(bus.rlast),   128'(0));
    end
    rest       = 1'b0;
    bus.rready = 1'b1;
    repeat (20) cycle();
    check("post_rst_idle", 128'(bus.rvalid), 128'(0));
    send_ar(4'd10, 32'hFFFF_FFE4, 6'd3, 3'b100, 2'b01);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
